// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command channel, response channel, sticky control and
// ALU operand/result bus for the registered ALU front end.
// slave  = the sequencer side, master = the side that drives commands and
// hosts the combinational ALU.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high; the initiator holds valid and its
// payload stable until that edge, and valid never depends combinationally
// on ready.
interface alu_sequencer_if #(
    parameter int N = 32
);
    // Command channel
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_acc;

    // Response channel
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_z;
    logic         rsp_overflow;
    logic         rsp_zero;
    logic         rsp_equal;
    logic         rsp_err;

    // Sticky overflow
    logic         sticky_ovf;
    logic         clr_sticky;

    // ALU attachment
    logic [N-1:0] alu_x;
    logic [N-1:0] alu_y;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_z;
    logic         alu_overflow;
    logic         alu_equal;
    logic         alu_zero;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
        output cmd_ready,
        output rsp_valid, rsp_z, rsp_overflow, rsp_zero, rsp_equal, rsp_err,
        input  rsp_ready,
        output sticky_ovf,
        input  clr_sticky,
        output alu_x, alu_y, alu_op,
        input  alu_z, alu_overflow, alu_equal, alu_zero
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
        input  cmd_ready,
        input  rsp_valid, rsp_z, rsp_overflow, rsp_zero, rsp_equal, rsp_err,
        output rsp_ready,
        input  sticky_ovf,
        output clr_sticky,
        input  alu_x, alu_y, alu_op,
        output alu_z, alu_overflow, alu_equal, alu_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: registered command front end for a 32-bit combinational ALU.
// One command at a time: IDLE accepts and loads the ALU operand registers,
// EXEC lets the ALU settle for one cycle and captures its outputs, RESP holds
// the captured response until the consumer takes it. An accumulator keeps
// the last good result so commands can chain on it, and a sticky flag
// remembers any overflow until software clears it.
// Debug outputs expose the FSM state and the accumulator.
module alu_sequencer (
    input  logic                 clk,
    input  logic                 rstb,
    alu_sequencer_if.slave       sif,
    output logic [1:0]           state_o,
    output logic [31:0]          acc_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_z_q;
    logic        rsp_overflow_q;
    logic        rsp_zero_q;
    logic        rsp_equal_q;
    logic        rsp_err_q;
    logic        err_q;
    logic [31:0] acc_q;
    logic        sticky_q;
    logic [31:0] alu_x_q;
    logic [31:0] alu_y_q;
    logic [3:0]  alu_op_q;

    logic        err_d;
    logic [31:0] alu_x_d;

    // Decode reserved op codes and select the X source for an incoming command.
    always_comb begin
        err_d   = (sif.cmd_op == 4'd4) || (sif.cmd_op >= 4'd11);
        alu_x_d = sif.cmd_acc ? acc_q : sif.cmd_a;
    end

    // Sequencer FSM with all its registered outputs, accumulator and sticky flag.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_z_q        <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_equal_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            err_q          <= 1'b0;
            acc_q          <= '0;
            sticky_q       <= 1'b0;
            alu_x_q        <= '0;
            alu_y_q        <= '0;
            alu_op_q       <= '0;
        end else begin
            // Clear first so a same-cycle set in EXEC overrides it.
            if (sif.clr_sticky) begin
                sticky_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (sif.cmd_valid) begin
                        alu_x_q     <= alu_x_d;
                        alu_y_q     <= sif.cmd_b;
                        alu_op_q    <= sif.cmd_op;
                        err_q       <= err_d;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end

                EXEC: begin
                    // ALU inputs have been stable for a full cycle; capture.
                    if (err_q) begin
                        rsp_z_q        <= '0;
                        rsp_overflow_q <= 1'b0;
                        rsp_zero_q     <= 1'b0;
                        rsp_equal_q    <= 1'b0;
                        rsp_err_q      <= 1'b1;
                    end else begin
                        rsp_z_q        <= sif.alu_z;
                        rsp_overflow_q <= sif.alu_overflow;
                        rsp_zero_q     <= sif.alu_zero;
                        rsp_equal_q    <= sif.alu_equal;
                        rsp_err_q      <= 1'b0;
                        acc_q          <= sif.alu_z;
                        if (sif.alu_overflow) begin
                            sticky_q <= 1'b1;
                        end
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end

                RESP: begin
                    if (sif.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign sif.cmd_ready    = cmd_ready_q;
    assign sif.rsp_valid    = rsp_valid_q;
    assign sif.rsp_z        = rsp_z_q;
    assign sif.rsp_overflow = rsp_overflow_q;
    assign sif.rsp_zero     = rsp_zero_q;
    assign sif.rsp_equal    = rsp_equal_q;
    assign sif.rsp_err      = rsp_err_q;
    assign sif.sticky_ovf   = sticky_q;
    assign sif.alu_x        = alu_x_q;
    assign sif.alu_y        = alu_y_q;
    assign sif.alu_op       = alu_op_q;

    assign state_o = state_q;
    assign acc_o   = acc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a behavioural
// 32-bit ALU attached to the operand/result bus.
module tb_alu_sequencer;

    logic        clk;
    logic        rstb;
    logic [1:0]  state_o;
    logic [31:0] acc_o;

    int checks = 0;
    int errors = 0;

    alu_sequencer_if sif();

    alu_sequencer dut (
        .clk     (clk),
        .rstb    (rstb),
        .sif     (sif),
        .state_o (state_o),
        .acc_o   (acc_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. Reserved ops return junk and raise overflow so a
    // sequencer that fails to mask them is visible.
    logic [31:0] m_x, m_y, m_z;
    logic        m_ovf;
    always_comb begin
        m_x   = sif.alu_x;
        m_y   = sif.alu_y;
        m_z   = 32'hDEADBEEF;
        m_ovf = 1'b1;
        case (sif.alu_op)
            4'd0:  begin m_z = m_x & m_y;    m_ovf = 1'b0; end
            4'd1:  begin m_z = m_x | m_y;    m_ovf = 1'b0; end
            4'd2:  begin m_z = m_x ^ m_y;    m_ovf = 1'b0; end
            4'd3:  begin m_z = ~(m_x | m_y); m_ovf = 1'b0; end
            4'd5:  begin
                m_z   = m_x + m_y;
                m_ovf = (m_x[31] == m_y[31]) && (m_z[31] != m_x[31]);
            end
            4'd6:  begin
                m_z   = m_x - m_y;
                m_ovf = (m_x[31] != m_y[31]) && (m_z[31] != m_x[31]);
            end
            4'd7:  begin m_z = ($signed(m_x) < $signed(m_y)) ? 32'd1 : 32'd0; m_ovf = 1'b0; end
            4'd8:  begin m_z = m_x >> m_y[4:0];  m_ovf = 1'b0; end
            4'd9:  begin m_z = m_x << m_y[4:0];  m_ovf = 1'b0; end
            4'd10: begin m_z = $unsigned($signed(m_x) >>> m_y[4:0]); m_ovf = 1'b0; end
            default: begin m_z = 32'hDEADBEEF; m_ovf = 1'b1; end
        endcase
        sif.alu_z        = m_z;
        sif.alu_overflow = m_ovf;
        sif.alu_zero     = (m_z == 32'd0);
        sif.alu_equal    = (m_x == m_y);
    end

    // Scoreboard checks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, presents a command for one accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_acc);
        int n;
        n = 0;
        while (!sif.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check1("cmd_ready_before_issue", sif.cmd_ready, 1'b1);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = op;
        sif.cmd_a     = a;
        sif.cmd_b     = b;
        sif.cmd_acc   = use_acc;
        tick();
        sif.cmd_valid = 1'b0;
        sif.cmd_a     = 32'h5A5A5A5A;
        sif.cmd_b     = 32'hA5A5A5A5;
    endtask

    // Bounded wait for rsp_valid.
    task automatic wait_rsp();
        int n;
        n = 0;
        while (!sif.rsp_valid && n < 10) begin
            tick();
            n++;
        end
        check1("rsp_valid_wait", sif.rsp_valid, 1'b1);
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] z, input logic ovf,
                             input logic zero, input logic eq, input logic err);
        check({tag, "_z"}, sif.rsp_z, z);
        check1({tag, "_ovf"}, sif.rsp_overflow, ovf);
        check1({tag, "_zero"}, sif.rsp_zero, zero);
        check1({tag, "_equal"}, sif.rsp_equal, eq);
        check1({tag, "_err"}, sif.rsp_err, err);
    endtask

    initial begin
        rstb           = 1'b0;
        sif.cmd_valid  = 1'b0;
        sif.cmd_op     = 4'd0;
        sif.cmd_a      = 32'd0;
        sif.cmd_b      = 32'd0;
        sif.cmd_acc    = 1'b0;
        sif.rsp_ready  = 1'b1;
        sif.clr_sticky = 1'b0;

        // Reset values
        tick();
        tick();
        rstb = 1'b1;
        check("rst_state", {30'd0, state_o}, 32'd0);
        check1("rst_cmd_ready", sif.cmd_ready, 1'b1);
        check1("rst_rsp_valid", sif.rsp_valid, 1'b0);
        check_rsp("rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_acc", acc_o, 32'd0);
        check1("rst_sticky", sif.sticky_ovf, 1'b0);
        check("rst_alu_x", sif.alu_x, 32'd0);
        check("rst_alu_y", sif.alu_y, 32'd0);
        check("rst_alu_op", {28'd0, sif.alu_op}, 32'd0);

        // Basic ADD and latency: EXEC after accept edge, rsp_valid after the next.
        issue(4'd5, 32'd5, 32'd7, 1'b0);
        check("add_state_exec", {30'd0, state_o}, 32'd1);
        check1("add_rsp_valid_early", sif.rsp_valid, 1'b0);
        check1("add_cmd_ready_exec", sif.cmd_ready, 1'b0);
        check("add_alu_x", sif.alu_x, 32'd5);
        check("add_alu_y", sif.alu_y, 32'd7);
        check("add_alu_op", {28'd0, sif.alu_op}, 32'd5);
        tick();
        check1("add_rsp_valid_t2", sif.rsp_valid, 1'b1);
        check_rsp("add", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check1("add_cmd_ready_after", sif.cmd_ready, 1'b1);
        check1("add_rsp_valid_drop", sif.rsp_valid, 1'b0);
        check("add_alu_x_held", sif.alu_x, 32'd5);

        // Overflow and sticky flag
        issue(4'd5, 32'h7FFFFFFF, 32'd1, 1'b0);
        wait_rsp();
        check_rsp("ovf", 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0);
        check1("ovf_sticky", sif.sticky_ovf, 1'b1);
        tick();
        issue(4'd6, 32'd1, 32'd1, 1'b0);
        wait_rsp();
        check_rsp("sub", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check1("sub_sticky_held", sif.sticky_ovf, 1'b1);
        tick();
        sif.clr_sticky = 1'b1;
        tick();
        sif.clr_sticky = 1'b0;
        check1("sticky_cleared", sif.sticky_ovf, 1'b0);

        // Accumulate chain: 3+4, acc+10, acc<<2
        issue(4'd5, 32'd3, 32'd4, 1'b0);
        wait_rsp();
        check("chain1_z", sif.rsp_z, 32'd7);
        tick();
        issue(4'd5, 32'hFFFF0000, 32'd10, 1'b1);
        check("chain2_alu_x", sif.alu_x, 32'd7);
        wait_rsp();
        check("chain2_z", sif.rsp_z, 32'd17);
        tick();
        issue(4'd9, 32'h12345678, 32'd2, 1'b1);
        check("chain3_alu_x", sif.alu_x, 32'd17);
        wait_rsp();
        check("chain3_z", sif.rsp_z, 32'd68);
        check("chain3_acc", acc_o, 32'd68);
        tick();

        // Reserved op: acc=9 first, then op 12
        issue(4'd5, 32'd4, 32'd5, 1'b0);
        wait_rsp();
        check("resv_pre_acc", acc_o, 32'd9);
        tick();
        issue(4'd12, 32'd1, 32'd1, 1'b0);
        wait_rsp();
        check_rsp("resv", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("resv_acc", acc_o, 32'd9);
        check1("resv_sticky", sif.sticky_ovf, 1'b0);
        tick();
        issue(4'd4, 32'd3, 32'd2, 1'b0);
        wait_rsp();
        check1("resv4_err", sif.rsp_err, 1'b1);
        check("resv4_acc", acc_o, 32'd9);
        tick();

        // Backpressure on XOR
        sif.rsp_ready = 1'b0;
        issue(4'd2, 32'hF0F0F0F0, 32'hFFFF0000, 1'b0);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            check1("bp_rsp_valid", sif.rsp_valid, 1'b1);
            check("bp_rsp_z", sif.rsp_z, 32'h0F0FF0F0);
            check1("bp_cmd_ready", sif.cmd_ready, 1'b0);
            tick();
        end
        sif.rsp_ready = 1'b1;
        tick();
        check1("bp_cmd_ready_after", sif.cmd_ready, 1'b1);
        check1("bp_rsp_valid_after", sif.rsp_valid, 1'b0);
        check("bp_acc", acc_o, 32'h0F0FF0F0);

        // Reset during EXEC of ADD 1+1
        issue(4'd5, 32'd1, 32'd1, 1'b0);
        check("mid_state_exec", {30'd0, state_o}, 32'd1);
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        check("mid_state", {30'd0, state_o}, 32'd0);
        check1("mid_cmd_ready", sif.cmd_ready, 1'b1);
        check1("mid_rsp_valid", sif.rsp_valid, 1'b0);
        check_rsp("mid", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_acc", acc_o, 32'd0);
        check("mid_alu_x", sif.alu_x, 32'd0);
        check("mid_alu_y", sif.alu_y, 32'd0);
        check("mid_alu_op", {28'd0, sif.alu_op}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("mid_no_rsp", sif.rsp_valid, 1'b0);
        end

        // Signed shift after reset still works
        issue(4'd10, 32'h80000000, 32'd4, 1'b0);
        wait_rsp();
        check("sra_z", sif.rsp_z, 32'hF8000000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
